// File: rtl/titan_bus_pkg.sv
// titan_bus_pkg: shared constants for the core Wishbone bus arbiter
// and the LSU/memory slaves that talk to it.
package titan_bus_pkg;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] IGNT = 2'b01;
   localparam logic [1:0] DGNT = 2'b10;

   localparam int DEFAULT_TIMEOUT = 255;

   localparam logic [3:0] SEL_WORD = 4'hf;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   // Ties go to whichever master did not finish the previous grant.
   function automatic logic [1:0] pick_grant(
      input logic   ireq,
      input logic   dreq,
      input owner_e last
   );
      logic [1:0] g;
      g = IDLE;
      if (dreq && (!ireq || last == OWN_I))
         g = DGNT;
      else if (ireq)
         g = IGNT;
      return g;
   endfunction

endpackage

// File: rtl/titan_bus_timeout.sv
// titan_bus_timeout: wait-cycle counter for the bus arbiter; expire
// pulses in the cycle the count reaches TIMEOUT-1.
module titan_bus_timeout
   import titan_bus_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   assign expire = enable && (count == LAST);

   always_ff @(posedge clk_i) begin
      if (rst_i || clear)
         count <= '0;
      else if (enable && !expire)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/titan_bus_arbiter.sv
// titan_bus_arbiter: round-robin Wishbone classic arbiter merging the
// fetch and data ports onto the core bus, with hung-cycle timeout.
module titan_bus_arbiter
   import titan_bus_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int AW      = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [AW-1:0] iaddr_i,
   input  logic          icyc_i,
   input  logic          istb_i,
   output logic [31:0]   idat_o,
   output logic          iack_o,
   output logic          ierr_o,
   input  logic [AW-1:0] daddr_i,
   input  logic [31:0]   ddat_i,
   input  logic [3:0]    dsel_i,
   input  logic          dwe_i,
   input  logic          dcyc_i,
   input  logic          dstb_i,
   output logic [31:0]   ddat_o,
   output logic          dack_o,
   output logic          derr_o,
   output logic [AW-1:0] wbm_addr_o,
   output logic [31:0]   wbm_dat_o,
   output logic [3:0]    wbm_sel_o,
   output logic          wbm_we_o,
   output logic          wbm_cyc_o,
   output logic          wbm_stb_o,
   input  logic [31:0]   wbm_dat_i,
   input  logic          wbm_ack_i,
   input  logic          wbm_err_i
);

   logic [1:0] state;
   logic [1:0] state_nxt;
   owner_e     last_owner;

   logic ireq;
   logic dreq;
   logic granted;
   logic own_cyc;
   logic own_stb;
   logic to_en;
   logic to_exp;
   logic done;

   assign ireq    = icyc_i & istb_i;
   assign dreq    = dcyc_i & dstb_i;
   assign granted = (state == IGNT) || (state == DGNT);

   assign idat_o = wbm_dat_i;
   assign ddat_o = wbm_dat_i;

   titan_bus_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clear  (!granted),
      .enable (to_en),
      .expire (to_exp)
   );

   always_comb begin
      own_cyc    = 1'b0;
      own_stb    = 1'b0;
      wbm_addr_o = '0;
      wbm_dat_o  = '0;
      wbm_sel_o  = '0;
      wbm_we_o   = 1'b0;
      iack_o     = 1'b0;
      ierr_o     = 1'b0;
      dack_o     = 1'b0;
      derr_o     = 1'b0;
      case (state)
         IGNT: begin
            own_cyc    = icyc_i;
            own_stb    = istb_i;
            wbm_addr_o = iaddr_i;
            wbm_sel_o  = SEL_WORD;
            iack_o     = wbm_ack_i;
            ierr_o     = wbm_err_i | to_exp;
         end
         DGNT: begin
            own_cyc    = dcyc_i;
            own_stb    = dstb_i;
            wbm_addr_o = daddr_i;
            wbm_dat_o  = ddat_i;
            wbm_sel_o  = dsel_i;
            wbm_we_o   = dwe_i;
            dack_o     = wbm_ack_i;
            derr_o     = wbm_err_i | to_exp;
         end
         default: ;
      endcase
   end

   // Timeout drops the bus in the same cycle the owner sees err.
   assign wbm_cyc_o = own_cyc & ~to_exp;
   assign wbm_stb_o = own_stb & ~to_exp;

   assign to_en = granted & own_stb & ~wbm_ack_i & ~wbm_err_i;
   assign done  = granted &
                  (wbm_ack_i | wbm_err_i | ~own_cyc | to_exp);

   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = pick_grant(ireq, dreq, last_owner);
         IGNT,
         DGNT:    state_nxt = done ? IDLE : state;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         last_owner <= OWN_I;
      end else begin
         state <= state_nxt;
         if (done)
            last_owner <= (state == DGNT) ? OWN_D : OWN_I;
      end
   end

endmodule

// File: tb/tb_titan_bus_arbiter.sv
// tb_titan_bus_arbiter: directed scoreboard bench for the core bus
// arbiter, built with TIMEOUT=4.
module tb_titan_bus_arbiter;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdat;
      logic [3:0]  sel;
      logic        we;
      logic        cyc;
      logic        stb;
      logic        ia;
      logic        ie;
      logic        da;
      logic        de;
      logic [31:0] idat;
      logic [31:0] ddat;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] iaddr;
   logic        icyc, istb;
   logic [31:0] idat;
   logic        iack, ierr;
   logic [31:0] daddr, ddat_w;
   logic [3:0]  dsel;
   logic        dwe, dcyc, dstb;
   logic [31:0] ddat_r;
   logic        dack, derr;
   logic [31:0] waddr, wdat;
   logic [3:0]  wsel;
   logic        wwe, wcyc, wstb;
   logic [31:0] rdat;
   logic        ack, err;

   logic probe = 1'b0;
   logic done  = 1'b0;
   logic drained = 1'b0;
   int   checks = 0;
   int   failures = 0;

   rec_t  sb[$];
   string nmq[$];

   always #5 clk = ~clk;

   titan_bus_arbiter #(
      .TIMEOUT (4),
      .AW      (32)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .iaddr_i    (iaddr),
      .icyc_i     (icyc),
      .istb_i     (istb),
      .idat_o     (idat),
      .iack_o     (iack),
      .ierr_o     (ierr),
      .daddr_i    (daddr),
      .ddat_i     (ddat_w),
      .dsel_i     (dsel),
      .dwe_i      (dwe),
      .dcyc_i     (dcyc),
      .dstb_i     (dstb),
      .ddat_o     (ddat_r),
      .dack_o     (dack),
      .derr_o     (derr),
      .wbm_addr_o (waddr),
      .wbm_dat_o  (wdat),
      .wbm_sel_o  (wsel),
      .wbm_we_o   (wwe),
      .wbm_cyc_o  (wcyc),
      .wbm_stb_o  (wstb),
      .wbm_dat_i  (rdat),
      .wbm_ack_i  (ack),
      .wbm_err_i  (err)
   );

   // Monitor: pops one expectation per probed or active cycle.
   always @(negedge clk) begin
      rec_t  got;
      rec_t  e;
      string nm;
      logic  act;
      act = wcyc | wstb | iack | ierr | dack | derr;
      if (probe || act) begin
         got = '{addr: waddr, wdat: wdat, sel: wsel, we: wwe,
                 cyc: wcyc, stb: wstb, ia: iack, ie: ierr,
                 da: dack, de: derr, idat: idat, ddat: ddat_r};
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output got=%h exp=none", got);
         end else begin
            e  = sb.pop_front();
            nm = nmq.pop_front();
            if (got !== e) begin
               failures++;
               $display("FAIL %s got=%h exp=%h", nm, got, e);
            end
         end
      end
      if (done && !drained) begin
         drained = 1'b1;
         checks++;
         if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      probe = 1'b0;
   endtask

   task automatic exp(input string nm,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic we,
                      input logic cy, input logic st,
                      input logic ia, input logic ie,
                      input logic da, input logic de);
      rec_t r;
      r = '{addr: a, wdat: d, sel: s, we: we, cyc: cy, stb: st,
            ia: ia, ie: ie, da: da, de: de, idat: rdat, ddat: rdat};
      sb.push_back(r);
      nmq.push_back(nm);
      probe = 1'b1;
   endtask

   task automatic idle(input string nm);
      exp(nm, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic drop_all();
      icyc = 0; istb = 0; dcyc = 0; dstb = 0; ack = 0; err = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      rst = 1; rdat = 32'h1111_2222;
      iaddr = 0; icyc = 0; istb = 0;
      daddr = 0; ddat_w = 0; dsel = 0; dwe = 0; dcyc = 0; dstb = 0;
      ack = 0; err = 0;
      tick();
      idle("reset_state");
      tick();
      rst = 0;

      // Tie right after reset: data first, one dead cycle, then fetch
      rdat = 32'hCAFE_0001;
      iaddr = 32'h200; icyc = 1; istb = 1;
      daddr = 32'h300; ddat_w = 32'h0BAD_F00D; dsel = 4'hf; dwe = 0;
      dcyc = 1; dstb = 1;
      idle("tie_idle"); tick();
      ack = 1;
      exp("tie_dgnt", 32'h300, 32'h0BAD_F00D, 4'hf, 0, 1, 1, 0, 0, 1, 0);
      tick();
      ack = 0; dcyc = 0; dstb = 0;
      idle("tie_dead"); tick();
      ack = 1;
      exp("tie_ignt", 32'h200, 32'h0, 4'hf, 0, 1, 1, 1, 0, 0, 0);
      tick();
      drop_all();
      idle("tie_end"); tick();

      // Fairness: ack held high, so IDLE acks are also dropped
      rdat = 32'h5A5A_0002;
      iaddr = 32'h400; daddr = 32'h500; ddat_w = 32'hA5A5_A5A5;
      dsel = 4'hc; dwe = 1;
      icyc = 1; istb = 1; dcyc = 1; dstb = 1; ack = 1;
      for (int k = 0; k < 6; k++) begin
         idle("fair_dead"); tick();
         if (k % 2 == 0)
            exp("fair_d", 32'h500, 32'hA5A5_A5A5, 4'hc, 1, 1, 1,
                0, 0, 1, 0);
         else
            exp("fair_i", 32'h400, 32'h0, 4'hf, 0, 1, 1, 1, 0, 0, 0);
         tick();
      end
      drop_all();
      idle("fair_end"); tick();

      // Timeout: no ack, err in the 4th granted cycle
      rdat = 32'h0000_7777;
      iaddr = 32'h600; icyc = 1; istb = 1;
      idle("to_idle"); tick();
      for (int j = 0; j < 3; j++) begin
         exp("to_wait", 32'h600, 32'h0, 4'hf, 0, 1, 1, 0, 0, 0, 0);
         tick();
      end
      exp("to_expire", 32'h600, 32'h0, 4'hf, 0, 0, 0, 0, 1, 0, 0);
      tick();
      drop_all();
      idle("to_after"); tick();

      // Abort: fetch drops cyc, late ack must vanish
      iaddr = 32'h700; icyc = 1; istb = 1;
      idle("ab_idle"); tick();
      exp("ab_wait", 32'h700, 32'h0, 4'hf, 0, 1, 1, 0, 0, 0, 0);
      tick();
      icyc = 0; istb = 0;
      exp("ab_drop", 32'h700, 32'h0, 4'hf, 0, 0, 0, 0, 0, 0, 0);
      tick();
      ack = 1;
      idle("ab_late_ack"); tick();
      ack = 0;
      idle("ab_end"); tick();

      // Slave error goes to the owner only
      iaddr = 32'hA00; icyc = 1; istb = 1;
      idle("err_idle"); tick();
      err = 1;
      exp("err_ignt", 32'hA00, 32'h0, 4'hf, 0, 1, 1, 0, 1, 0, 0);
      tick();
      drop_all();
      idle("err_end"); tick();

      // Data-only write with two wait states
      rdat = 32'h3333_4444;
      daddr = 32'h100; ddat_w = 32'hDEAD_BEEF; dsel = 4'h3; dwe = 1;
      dcyc = 1; dstb = 1;
      idle("d_req"); tick();
      for (int j = 0; j < 2; j++) begin
         exp("d_wait", 32'h100, 32'hDEAD_BEEF, 4'h3, 1, 1, 1,
             0, 0, 0, 0);
         tick();
      end
      ack = 1;
      exp("d_ack", 32'h100, 32'hDEAD_BEEF, 4'h3, 1, 1, 1, 0, 0, 1, 0);
      tick();
      drop_all();
      idle("d_end"); tick();

      // Reset mid-DGNT (last owner is data here), then a tie
      daddr = 32'h800; ddat_w = 32'h1234_5678; dsel = 4'hf; dwe = 1;
      dcyc = 1; dstb = 1;
      idle("rs_req"); tick();
      rst = 1;
      exp("rs_dgnt", 32'h800, 32'h1234_5678, 4'hf, 1, 1, 1, 0, 0, 0, 0);
      tick();
      ack = 1; iaddr = 32'h900; icyc = 1; istb = 1;
      idle("rs_released"); tick();
      rst = 0;
      idle("rs_tie_idle"); tick();
      exp("rs_tie_dgnt", 32'h800, 32'h1234_5678, 4'hf, 1, 1, 1,
          0, 0, 1, 0);
      tick();
      drop_all();
      idle("rs_end"); tick();

      done = 1'b1;
      tick();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/titan_bus_arbiter.md
# titan_bus_arbiter

- Two-master, one-slave Wishbone classic arbiter directly downstream of the load/store unit.
- Merges the LSU instruction-fetch port and data port onto the single core bus that leads to memory and peripherals.
- Grants one master at a time with round-robin fairness, routes ack/err/read data back to the owning master, and terminates hung cycles with a bus-timeout error.

## Interface
Parameters:
- TIMEOUT, 255, wait cycles without ack/err before the arbiter terminates the cycle with err; legal range 2..65535
- AW, 32, address width

Ports:
- clk_i  in  1  core clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- iaddr_i  in  AW  instruction master address
- icyc_i  in  1  instruction master cycle
- istb_i  in  1  instruction master strobe
- idat_o  out  32  instruction read data
- iack_o  out  1  instruction ack
- ierr_o  out  1  instruction error
- daddr_i  in  AW  data master address
- ddat_i  in  32  data master write data
- dsel_i  in  4  data master byte select
- dwe_i  in  1  data master write enable
- dcyc_i  in  1  data master cycle
- dstb_i  in  1  data master strobe
- ddat_o  out  32  data read data
- dack_o  out  1  data ack
- derr_o  out  1  data error
- wbm_addr_o  out  AW  bus address
- wbm_dat_o  out  32  bus write data
- wbm_sel_o  out  4  bus byte select
- wbm_we_o  out  1  bus write enable
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  bus strobe
- wbm_dat_i  in  32  bus read data
- wbm_ack_i  in  1  bus ack
- wbm_err_i  in  1  bus error

## Operation
- States: IDLE, IGNT, DGNT.
- Request: a master requests when cyc&stb are both high. cyc alone is not a request, because the fetch port holds cyc high between fetches.
- IDLE:
  - Only data requesting → DGNT.
  - Only instruction requesting → IGNT.
  - Both requesting → grant the master that did not own the last completed grant.
  - Reset sets last-owner = instruction, so data wins the first tie.
- Output muxing is combinational from the registered state.
  - In IDLE: wbm_cyc_o, wbm_stb_o and wbm_we_o are 0.
  - In IGNT: bus takes iaddr_i, icyc_i, istb_i; wbm_we_o=0, wbm_sel_o=4'hf, wbm_dat_o=0.
  - In DGNT: bus takes all d* inputs.
- Response routing: wbm_ack_i and wbm_err_i are routed only to the owner. The non-owner sees ack=0 and err=0 in all states. idat_o and ddat_o both carry wbm_dat_i unconditionally.
- End of grant: return to IDLE and update last-owner when any of the following occurs:
  - wbm_ack_i or wbm_err_i is high;
  - the owner drops cyc (abort, e.g. fetch kill);
  - timeout fires.
- Ack and err in the same cycle: both are forwarded, and the master treats it as err.
- Timeout:
  - The counter clears on entry to IGNT/DGNT.
  - It increments every granted cycle with stb high and no ack/err.
  - When count reaches TIMEOUT-1, that same cycle the owner's err_o is forced to 1 and wbm_cyc_o/wbm_stb_o are forced to 0. State returns to IDLE next cycle.
- Late ack/err arriving in IDLE is dropped and never reaches either master.

## Timing
- Reset values: state IDLE, last-owner instruction, counter 0. Outputs: all cyc/stb/we/ack/err are 0; addr/dat/sel follow the IDLE mux (0).
- Reset asserted mid-grant: the bus is released in the cycle after the rst_i edge; no ack/err is delivered.
- Grant latency: request first seen at edge N → bus cyc/stb high from cycle N+1.
- Response latency: zero. Slave ack in cycle M gives master ack in cycle M.
- Dead cycle: there is one IDLE cycle after every grant. Earliest next bus cycle is M+2, which guarantees the slave sees cyc low between owners.
- Back-to-back fetches with no data request: one transfer every 2 cycles minimum when the slave has zero wait states.

## Structure
- Shared package titan_bus_pkg holds:
  - the state encoding localparams (IDLE=2'b00, IGNT=2'b01, DGNT=2'b10);
  - DEFAULT_TIMEOUT=255;
  - a constant SEL_WORD=4'hf, reused by the LSU and memory slaves.
- One sub-module, titan_bus_timeout: width derived from TIMEOUT, with inputs clear/enable and a single-cycle expire output.

## Test plan
- Data-only: dcyc/dstb with daddr=0x100, dwe=1, ddat=0xDEADBEEF, dsel=4'h3; slave acks after 2 waits → bus shows the write one cycle after request; dack_o pulses in the ack cycle; iack_o stays 0.
- Tie after reset: both request in the same cycle → DGNT first. After its ack, IDLE for one cycle, then IGNT with wbm_we_o=0 and wbm_sel_o=4'hf.
- Fairness: both masters request continuously for 6 grants → strict alternation D,I,D,I,D,I.
- Timeout with TIMEOUT=4: slave never acks → ierr_o high exactly in the 4th granted cycle, wbm_cyc_o low that cycle, IDLE next cycle.
- Abort: instruction owner drops icyc_i mid-wait → wbm_cyc_o low the same cycle; slave ack one cycle later → iack_o and dack_o both stay 0.
- Reset mid-DGNT → wbm_cyc_o is 0 from the cycle after the rst_i edge; first post-reset tie is again granted to data.
